// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a 4-phase ratio-change handshake.
//
// clk_out is a registered 50%-duty clock with a period of 2*R clk_in cycles.
// tick pulses for one cycle on every clk_out toggle. A new half-period value
// is requested on div_req/div_val. It is applied only at a falling boundary
// of clk_out, or at once while the output is parked low with enable=0, so no
// clk_out phase is ever shortened.
//
// Optional feature macro: CLK_DIV_CTRL_ERR_EN
//   defined   : div_val=0 is rejected (IDLE -> DONE directly, R unchanged);
//               the div_err port flags the rejection while in DONE.
//   undefined : no div_err port; div_val=0 is captured as 1.
module clk_div_ctrl #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_CTRL_ERR_EN
  ,
  output logic             div_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] ratio_r;   // active half-period R
  logic [DIV_W-1:0] pend_r;    // pending half-period P
  logic [DIV_W-1:0] cnt;       // position inside the current half-period
  logic [DIV_W-1:0] ratio_m1;
  logic             at_wrap;   // last cycle of the current half-period
  logic             capture;   // latch div_val into P this cycle
  logic             apply;     // move P into R this cycle
  logic             reject;    // div_val=0 refused (error build only)

  assign ratio_m1 = ratio_r - DIV_W'(1);
  assign at_wrap  = (cnt == ratio_m1);
  assign busy     = (state == PEND);
  assign div_ack  = (state == DONE);

  // Handshake state register.
  // NOTE: sequential state always uses non-blocking (<=) assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the capture/apply strobes for the datapath.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    apply     = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (div_req) begin
          capture   = 1'b1;
          state_nxt = PEND;
`ifdef CLK_DIV_CTRL_ERR_EN
          if (div_val == '0) begin
            reject    = 1'b1;
            state_nxt = DONE;
          end
`endif
        end
      end
      PEND: begin
        // Apply on a falling clk_out boundary, or immediately while parked low.
        if ((enable && at_wrap && clk_out) || (!enable && !clk_out)) begin
          apply     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!div_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Divider counter, output clock, tick and ratio registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ratio_r <= DIV_W'(1);
      pend_r  <= '0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (at_wrap) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
      if (capture) begin
`ifdef CLK_DIV_CTRL_ERR_EN
        pend_r <= div_val;
`else
        // A zero half-period is meaningless; treat it as the fastest ratio.
        pend_r <= (div_val == '0) ? DIV_W'(1) : div_val;
`endif
      end
      // The new ratio governs the half-period that starts on this cycle.
      if (apply) begin
        ratio_r <= pend_r;
        cnt     <= '0;
      end
    end
  end

`ifdef CLK_DIV_CTRL_ERR_EN
  logic err_r;

  // Rejection flag: raised with the direct IDLE -> DONE step, cleared on return to IDLE.
  always_ff @(posedge clk_in) begin
    if (reset)                   err_r <= 1'b0;
    else if (reject)             err_r <= 1'b1;
    else if (state_nxt == IDLE)  err_r <= 1'b0;
  end

  assign div_err = err_r;
`else
  // Without the error feature a zero request is never refused.
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (DIV_W=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Observed vector order is {clk_out, tick, busy, div_ack}.
module tb_clk_div_ctrl;

  logic       clk_in;
  logic       reset;
  logic       enable;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       busy;
  logic       clk_out;
  logic       tick;
`ifdef CLK_DIV_CTRL_ERR_EN
  logic       div_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] obs;
  assign obs = {clk_out, tick, busy, div_ack};

  clk_div_ctrl #(.DIV_W(8)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (enable),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .busy    (busy),
    .clk_out (clk_out),
    .tick    (tick)
`ifdef CLK_DIV_CTRL_ERR_EN
    ,
    .div_err (div_err)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    div_req = 1'b1;
    div_val = 8'd9;
    for (int j = 1; j <= 2; j++) begin
      step();
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: {clk_out,tick,busy,div_ack} got %b want 0000", j, obs);
      end
      checks++;
`ifdef CLK_DIV_CTRL_ERR_EN
      if (div_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_err cycle %0d: div_err got %b want 0", j, div_err);
      end
      checks++;
`endif
    end
    div_req = 1'b0;
    enable  = 1'b0;
    reset   = 1'b0;
  endtask

  // R=1: plain divide-by-2, tick every cycle.
  task automatic test_div2();
    logic [3:0] exp;
    enable = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      exp = {(j % 2) == 1, 1'b1, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL div2 cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // R=1 -> 3 while running; applied on the falling boundary.
  task automatic test_change3();
    logic [3:0] exp;
    div_val = 8'd3;
    div_req = 1'b1;
    step();
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL change3_pend: got %b want 1110", obs);
    end
    checks++;
    step();
    if (obs !== 4'b0101) begin
      errors++;
      $display("FAIL change3_apply: got %b want 0101", obs);
    end
    checks++;
    div_req = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp = {((j / 3) % 2) == 1, (j % 3) == 0, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL change3_period cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // R=3 -> 5 requested while frozen high; applies after re-enable at the fall.
  task automatic test_park_high();
    logic [3:0] exp;
    for (int j = 1; j <= 3; j++) begin
      step();
      exp = (j == 3) ? 4'b1100 : 4'b0000;
      if (obs !== exp) begin
        errors++;
        $display("FAIL park_high_setup cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
    enable  = 1'b0;
    div_val = 8'd5;
    div_req = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL park_high_frozen cycle %0d: got %b want 1010", j, obs);
      end
      checks++;
    end
    enable = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      exp = (j == 3) ? 4'b0101 : 4'b1010;
      if (obs !== exp) begin
        errors++;
        $display("FAIL park_high_apply cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
    div_req = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      exp = {((j / 5) % 2) == 1, (j % 5) == 0, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL park_high_period cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // Parked low: change applies while disabled. 5 -> 4, then 4 -> 2.
  task automatic test_park_low();
    logic [3:0] exp;
    enable  = 1'b0;
    div_val = 8'd4;
    div_req = 1'b1;
    step();
    step();
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL park_low_to4: got %b want 0001", obs);
    end
    checks++;
    div_req = 1'b0;
    step();
    div_val = 8'd2;
    div_req = 1'b1;
    step();
    if (obs !== 4'b0010) begin
      errors++;
      $display("FAIL park_low_pend: got %b want 0010", obs);
    end
    checks++;
    step();
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL park_low_done: got %b want 0001", obs);
    end
    checks++;
    div_req = 1'b0;
    enable  = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      exp = {((j / 2) % 2) == 1, (j % 2) == 0, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL park_low_period cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // R=2: enable low mid half-period holds the counter position.
  task automatic test_enable_hold();
    logic [3:0] want [0:6];
    want = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1000, 4'b0100};
    for (int j = 0; j < 7; j++) begin
      enable = !(j >= 1 && j <= 3);
      step();
      if (obs !== want[j]) begin
        errors++;
        $display("FAIL enable_hold cycle %0d: got %b want %b", j, obs, want[j]);
      end
      checks++;
    end
  endtask

  // Reset while PEND (R=2, P=7): change discarded, never acknowledged.
  task automatic test_reset_pend();
    logic [3:0] exp;
    enable  = 1'b1;
    div_val = 8'd7;
    div_req = 1'b1;
    step();
    if (obs !== 4'b0010) begin
      errors++;
      $display("FAIL reset_pend_pend: got %b want 0010", obs);
    end
    checks++;
    reset = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step();
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_pend_reset cycle %0d: got %b want 0000", j, obs);
      end
      checks++;
    end
    reset   = 1'b0;
    div_req = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      exp = {(j % 2) == 1, 1'b1, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_pend_after cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // Request equal to the current ratio (R=1) still runs PEND -> DONE.
  task automatic test_same_ratio();
    logic [3:0] exp;
    enable  = 1'b0;
    div_val = 8'd1;
    div_req = 1'b1;
    step();
    if (obs !== 4'b0010) begin
      errors++;
      $display("FAIL same_ratio_pend: got %b want 0010", obs);
    end
    checks++;
    step();
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL same_ratio_done: got %b want 0001", obs);
    end
    checks++;
    div_req = 1'b0;
    step();
    enable = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      exp = {(j % 2) == 1, 1'b1, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL same_ratio_period cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
  endtask

  // div_val=0 from R=3.
  task automatic test_zero();
    logic [3:0] exp;
    enable  = 1'b0;
    div_val = 8'd3;
    div_req = 1'b1;
    step();
    step();
    div_req = 1'b0;
    step();
    enable  = 1'b1;
    div_val = 8'd0;
    div_req = 1'b1;
`ifdef CLK_DIV_CTRL_ERR_EN
    step();
    if (obs !== 4'b0001 || div_err !== 1'b1) begin
      errors++;
      $display("FAIL zero_reject: got %b err %b want 0001 err 1", obs, div_err);
    end
    checks++;
    div_req = 1'b0;
    for (int j = 2; j <= 12; j++) begin
      step();
      exp = {((j / 3) % 2) == 1, (j % 3) == 0, 1'b0, 1'b0};
      if (obs !== exp || div_err !== 1'b0) begin
        errors++;
        $display("FAIL zero_keep_ratio cycle %0d: got %b err %b want %b err 0", j, obs, div_err, exp);
      end
      checks++;
    end
`else
    for (int j = 1; j <= 6; j++) begin
      step();
      exp = (j == 6) ? 4'b0101 : {j >= 3, j == 3, 1'b1, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_as_one cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
    div_req = 1'b0;
    for (int j = 7; j <= 12; j++) begin
      step();
      exp = {((j - 6) % 2) == 1, 1'b1, 1'b0, 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_period cycle %0d: got %b want %b", j, obs, exp);
      end
      checks++;
    end
`endif
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    div_req = 1'b0;
    div_val = '0;
    test_reset();
    test_div2();
    test_change3();
    test_park_high();
    test_park_low();
    test_enable_hold();
    test_reset_pend();
    test_same_ratio();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The module SHALL have parameter DIV_W, default 8, giving the width of the divide-ratio field.
REQ-002 The module SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port enable, input, 1 bit: run enable; low freezes the counter and clk_out.
REQ-005 The module SHALL have port div_req, input, 1 bit: ratio-change request (4-phase handshake).
REQ-006 The module SHALL have port div_val, input, DIV_W bits: requested half-period in clk_in cycles; stable while div_req is high.
REQ-007 The module SHALL have port div_ack, output, 1 bit: ratio-change acknowledge (level).
REQ-008 The module SHALL have port busy, output, 1 bit: high while a ratio change is pending.
REQ-009 The module SHALL have port clk_out, output, 1 bit: divided clock, registered.
REQ-010 The module SHALL have port tick, output, 1 bit: one-cycle pulse on every clk_out toggle.
REQ-011 The module SHALL have port div_err, output, 1 bit: rejected request flag; the port is present only with CLK_DIV_CTRL_ERR_EN.

Function
REQ-012 The module SHALL hold a ratio register R (reset value 1) and a half-period counter cnt (DIV_W bits).
- With R = 1, clk_out behaves as a plain divide-by-2.
REQ-013 Each cycle with enable=1, the module SHALL increment cnt, or, when cnt == R-1, clear cnt, invert clk_out and assert tick for that same registered cycle.
- clk_out period = 2*R clk_in cycles, 50% duty.
REQ-014 With enable=0, the module SHALL hold cnt and clk_out and keep tick at 0.
REQ-015 The handshake FSM SHALL have states IDLE, PEND and DONE, with the following transitions.
- IDLE -> PEND when div_req=1: capture div_val into pending register P.
- PEND -> DONE at the apply point: R<=P, cnt<=0.
- DONE -> IDLE when div_req=0.
- div_req is ignored in PEND and DONE.
REQ-016 The apply point SHALL be either of the following.
- A cycle where enable=1, cnt==R-1 and clk_out==1, i.e. a falling boundary of clk_out. That clk_out toggle still occurs, so no period is shortened.
- Any cycle in PEND where enable=0 and clk_out==0, i.e. the output is parked low.
REQ-017 The module SHALL drive div_ack high exactly in state DONE and busy high exactly in state PEND.
REQ-018 A request with div_val equal to the current R SHALL still complete through PEND and DONE.
REQ-019 The module SHALL handle div_val=0 as defined under Configuration.
REQ-020 The new ratio SHALL first govern the half-period that begins on the apply cycle.

Reset
REQ-021 When reset=1 at a clk_in edge, the module SHALL set all of the following:
- R=1, cnt=0, P=0, FSM=IDLE;
- clk_out=0, tick=0, div_ack=0, busy=0, div_err=0.
REQ-022 Reset SHALL take priority over enable and div_req.
- A pending change is discarded mid-operation without an acknowledge.

Configuration
REQ-023 With macro CLK_DIV_CTRL_ERR_EN defined, a request captured with div_val=0 SHALL be handled as follows.
- It goes IDLE -> DONE on the next cycle, bypassing PEND, with R unchanged.
- div_err is high during that DONE and cleared on return to IDLE.
REQ-024 Without CLK_DIV_CTRL_ERR_EN, the module SHALL omit the div_err port and capture div_val=0 as 1, with normal PEND/DONE sequencing.

Verification
REQ-025 Reset, then enable=1 for 8 cycles -> clk_out toggles every cycle (period 2), tick=1 every cycle, div_ack=0, busy=0.
REQ-026 At R=1 raise div_req with div_val=3 -> busy=1 until the next falling clk_out edge, then div_ack=1; clk_out subsequently has period 6 with 3 high and 3 low; drop div_req -> div_ack=0 next cycle.
REQ-027 At R=3 with enable=0 and clk_out=1, request div_val=5 -> busy stays 1; at re-enable the change applies at the falling boundary; resulting period is 10.
REQ-028 At R=4 with enable=0 and clk_out=0, request div_val=2 -> DONE entered within 2 cycles; after enable, period is 4.
REQ-029 Assert reset while in PEND (R=2, P=7) -> next cycle R=1, busy=0, div_ack=0, clk_out=0; no acknowledge is ever issued for P.
REQ-030 Request div_val=0 -> with CLK_DIV_CTRL_ERR_EN: div_ack=1 and div_err=1 within 2 cycles, with R unchanged; without the macro: R becomes 1 at the next falling boundary.
